rng_arb: RTL and testbench

//  Shares one rng range generator between N_REQ requesters, each presenting a rng cfg

---
 rtl/rng_arb_pkg.sv | 54 +++++
 rtl/rng_arb_if.sv | 13 +
 rtl/rng_arb_rr_arbiter.sv | 33 +++
 rtl/rng_arb.sv | 129 ++++++++++++
 tb/tb_rng_arb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the rng range-generator arbiter.
// No logic of its own; the round-robin search is a pure function.
// Also defines the tagged output word layout {id, eot, data}.
package rng_arb_pkg;

  // Default sizing of the served rng instance.
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_W_DATA = 17;
  localparam int TAG_W_ID   = $clog2(DEF_N_REQ);

  // Upper bound on requesters the search function can handle.
  localparam int MAX_REQ    = 32;
  localparam int MAX_REQ_W  = $clog2(MAX_REQ);
  localparam int IDX_EXT_W  = MAX_REQ_W + 1;

  // Arbiter FSM: IDLE picks a winner, BUSY holds it for a whole sequence.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Layout of a downstream beat for the default sizing.
  typedef struct packed {
    logic [TAG_W_ID-1:0]     id;
    logic                    eot;
    logic [DEF_W_DATA-2:0]   data;
  } dout_tag_t;

  // First requester with valid set, scanning ptr, ptr+1, ... modulo n.
  // Returns ptr when nothing is valid (caller gates with |valid).
  function automatic logic [MAX_REQ_W-1:0] rr_next(
    input int unsigned            n,
    input logic [MAX_REQ_W-1:0]   ptr,
    input logic [MAX_REQ-1:0]     valid
  );
    logic [IDX_EXT_W-1:0] idx;
    logic [MAX_REQ_W-1:0] win;
    logic                 found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + IDX_EXT_W'(k);
      if (32'(idx) >= n) begin
        idx = idx - IDX_EXT_W'(n);
      end
      if (!found && (k < n) && valid[idx[MAX_REQ_W-1:0]]) begin
        win   = idx[MAX_REQ_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rng_arb_if.sv
// Generic valid/ready data channel used for cfg, rng output and tagged output.
// Zero latency: a plain bundle of wires.
// Transfer happens on a cycle where valid and ready are both high.
interface rng_arb_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rng_arb_rr_arbiter.sv
// Combinational round-robin picker: onehot grant plus index of the winner.
// Latency: none (pure combinational).
// No backpressure; o_any qualifies the grant outputs.
module rng_arb_rr_arbiter
  import rng_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int W_IDX = $clog2(N)
) (
  input  logic [W_IDX-1:0] i_ptr,
  input  logic [N-1:0]     i_valid,
  output logic [N-1:0]     o_grant,
  output logic [W_IDX-1:0] o_idx,
  output logic             o_any
);

  logic [MAX_REQ-1:0]   w_valid_ext;
  logic [MAX_REQ_W-1:0] w_win;

  assign w_valid_ext = MAX_REQ'(i_valid);

  // Scan from the pointer and convert the winner to onehot form.
  always_comb begin
    w_win   = rr_next(N, MAX_REQ_W'(i_ptr), w_valid_ext);
    o_any   = |i_valid;
    o_idx   = W_IDX'(w_win);
    o_grant = '0;
    if (o_any) begin
      o_grant = N'(1) << o_idx;
    end
  end

endmodule

// File: rtl/rng_arb.sv
// Shares one rng generator among N_REQ cfg producers, round-robin per sequence.
// Latency: 1 cycle to arbitrate, then zero-latency cfg/dout muxing per beat.
// Backpressure: dout.ready passes straight to rng_dout.ready; losers stall.
module rng_arb
  import rng_arb_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int W_CFG  = 48,
  parameter  int W_DATA = 17,
  localparam int W_ID   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*W_CFG-1:0] i_req_data,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  rng_arb_if.master              o_rng_cfg,
  rng_arb_if.slave               i_rng_dout,
  rng_arb_if.master              o_dout,
  output logic                   o_busy,
  output logic [W_ID-1:0]        o_grant_id
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [W_ID-1:0]  r_rr_ptr;
  logic [W_ID-1:0]  r_grant_id;
  logic [N_REQ-1:0] r_grant_oh;
  logic [W_ID-1:0]  w_ptr_nxt;

  logic [N_REQ-1:0] w_arb_oh;
  logic [W_ID-1:0]  w_arb_idx;
  logic             w_arb_any;
  logic             w_take;
  logic             w_seq_end;

  logic [W_CFG-1:0] w_req_cfg [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_cfg[gi] = i_req_data[gi*W_CFG +: W_CFG];
  end

  rng_arb_rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .i_ptr   (r_rr_ptr),
    .i_valid (i_req_valid),
    .o_grant (w_arb_oh),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Pointer moves to the requester after the one just served, wrapping at N_REQ-1.
  assign w_ptr_nxt = (r_grant_id == W_ID'(N_REQ - 1)) ? '0 : r_grant_id + W_ID'(1);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all channel muxing; reset forces every handshake output low.
  always_comb begin
    w_state_nxt       = r_state;
    w_take            = 1'b0;
    w_seq_end         = 1'b0;
    o_req_ready       = '0;
    o_rng_cfg.data    = w_req_cfg[r_grant_id];
    o_rng_cfg.valid   = 1'b0;
    i_rng_dout.ready  = 1'b0;
    o_dout.data       = {r_grant_id, i_rng_dout.data};
    o_dout.valid      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_take      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        o_rng_cfg.valid  = i_req_valid[r_grant_id];
        i_rng_dout.ready = o_dout.ready;
        o_dout.valid     = i_rng_dout.valid;
        // The rng accepts the cfg word only on its eot beat.
        if (o_rng_cfg.valid && o_rng_cfg.ready) begin
          w_seq_end   = 1'b1;
          o_req_ready = r_grant_oh;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      o_req_ready      = '0;
      o_rng_cfg.valid  = 1'b0;
      i_rng_dout.ready = 1'b0;
      o_dout.valid     = 1'b0;
    end
  end

  // Capture the winner on entry to BUSY; advance the pointer at sequence end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_id <= '0;
      r_grant_oh <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_take) begin
        r_grant_id <= w_arb_idx;
        r_grant_oh <= w_arb_oh;
      end
      if (w_seq_end) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign o_busy     = (r_state == BUSY);
  assign o_grant_id = r_grant_id;

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(o_req_ready));
  a_ready_busy   : assert property (@(posedge clk) disable iff (rst) (|o_req_ready) |-> o_busy);

endmodule

// File: tb/tb_rng_arb.sv
// Bench for rng_arb with a behavioural rng generator and a dout scoreboard.
// Expected beats are queued in predicted grant order as stimulus is issued.
// dout ready is driven by the bench, including stall patterns.
module tb_rng_arb;
  import rng_arb_pkg::*;

  localparam int N      = 4;
  localparam int W_CFG  = 48;
  localparam int W_DATA = 17;
  localparam int W_ID   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W_CFG-1:0] req_data;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic               busy;
  logic [W_ID-1:0]    grant_id;
  logic [W_CFG-1:0]   req_cfg [N];
  logic               req_vld [N];
  logic               dout_rdy;

  rng_arb_if #(.W(W_CFG))         rng_cfg_if ();
  rng_arb_if #(.W(W_DATA))        rng_dout_if ();
  rng_arb_if #(.W(W_DATA + W_ID)) dout_if ();

  rng_arb #(
    .N_REQ  (N),
    .W_CFG  (W_CFG),
    .W_DATA (W_DATA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .o_rng_cfg   (rng_cfg_if),
    .i_rng_dout  (rng_dout_if),
    .o_dout      (dout_if),
    .o_busy      (busy),
    .o_grant_id  (grant_id)
  );

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]                 = req_vld[i];
      req_data[i*W_CFG +: W_CFG]   = req_cfg[i];
    end
  end

  assign dout_if.ready = dout_rdy;

  // Behavioural rng: cfg {incr, cnt, base} -> cnt beats base + k*incr, eot on last.
  logic [15:0] m_idx;
  logic [15:0] m_incr, m_cnt, m_base, m_val;
  logic        m_eot;
  always_comb begin
    m_incr = rng_cfg_if.data[47:32];
    m_cnt  = rng_cfg_if.data[31:16];
    m_base = rng_cfg_if.data[15:0];
    m_eot  = (m_idx == m_cnt - 16'd1);
    m_val  = m_base + m_idx * m_incr;
  end
  assign rng_dout_if.valid = rng_cfg_if.valid;
  assign rng_dout_if.data  = {m_eot, m_val};
  assign rng_cfg_if.ready  = rng_dout_if.valid & rng_dout_if.ready & m_eot;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_idx <= '0;
    else if (rng_dout_if.valid && rng_dout_if.ready) m_idx <= m_eot ? 16'd0 : m_idx + 16'd1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  dout_tag_t exp_q [$];

  task automatic push_seq(input logic [W_ID-1:0] id, input logic [15:0] incr,
                          input logic [15:0] cnt, input logic [15:0] base);
    dout_tag_t e;
    for (int j = 0; j < int'(cnt); j++) begin
      e.id   = id;
      e.eot  = (j == int'(cnt) - 1);
      e.data = base + 16'(j) * incr;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: scoreboard on every dout transfer, req_ready and ready mirroring.
  int   cyc = 0;
  int   last_eot_cyc = -100;
  int   gap_from_cyc = 1000000;
  logic gap_en = 1'b0;
  logic prev_eot = 1'b0;
  always @(negedge clk) begin
    dout_tag_t e;
    cyc++;
    if (!rst) begin
      if (dout_if.valid && dout_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("dout", 64'(dout_if.data), 64'(e));
          chk("req_ready_beat", 64'(req_ready), e.eot ? (64'd1 << e.id) : 64'd0);
          if (gap_en && prev_eot && last_eot_cyc >= gap_from_cyc)
            chk("idle_gap", 64'(cyc - last_eot_cyc), 64'd2);
          prev_eot = e.eot;
          if (e.eot) last_eot_cyc = cyc;
        end
      end else begin
        chk("req_ready_idle", 64'(req_ready), 64'd0);
      end
      if (busy) chk("rdy_mirror", 64'(rng_dout_if.ready), 64'(dout_if.ready));
    end
  end

  // Present one cfg and hold it until its req_ready pulse; optional valid drop.
  task automatic drive_req(input int i, input logic [15:0] incr, input logic [15:0] cnt,
                           input logic [15:0] base, input int drop_at, input int drop_len);
    int   nb = 0;
    logic dropped = 1'b0;
    req_cfg[i] = {incr, cnt, base};
    req_vld[i] = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        req_vld[i] = 1'b0;
        return;
      end
      if (dout_if.valid && dout_if.ready && busy && int'(grant_id) == i) nb++;
      if (drop_len > 0 && !dropped && nb == drop_at) begin
        @(posedge clk);
        #1;
        req_vld[i] = 1'b0;
        repeat (drop_len) begin
          @(negedge clk);
          chk("drop_busy", 64'(busy), 64'd1);
          chk("drop_dout_vld", 64'(dout_if.valid), 64'd0);
        end
        @(posedge clk);
        #1;
        req_vld[i] = 1'b1;
        dropped = 1'b1;
      end
    end
    chk("drv_timeout", 64'(req_vld[i]), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_cfg_vld"}, 64'(rng_cfg_if.valid), 64'd0);
    chk({tag, "_rng_rdy"}, 64'(rng_dout_if.ready), 64'd0);
    chk({tag, "_dout_vld"}, 64'(dout_if.valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  logic [3:0] rdy_pat;

  initial begin
    rst      = 1'b1;
    dout_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_vld[i] = 1'b0;
      req_cfg[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester 0: beats 0,1,2 with eot on the last.
    push_seq(0, 16'd1, 16'd3, 16'd0);
    drive_req(0, 16'd1, 16'd3, 16'd0, 0, 0);

    // Requester 2 alone leaves the pointer at 3; then 1 and 3 together -> 3 first.
    push_seq(2, 16'd5, 16'd2, 16'd40);
    drive_req(2, 16'd5, 16'd2, 16'd40, 0, 0);
    push_seq(3, 16'd3, 16'd3, 16'd300);
    push_seq(1, 16'd7, 16'd2, 16'd100);
    fork
      drive_req(1, 16'd7, 16'd2, 16'd100, 0, 0);
      drive_req(3, 16'd3, 16'd3, 16'd300, 0, 0);
    join

    // Requester 1 with dout ready toggling 1,0,0,1.
    rdy_pat = 4'b1001;
    push_seq(1, 16'd2, 16'd6, 16'd10);
    fork
      drive_req(1, 16'd2, 16'd6, 16'd10, 0, 0);
      begin
        for (int c = 0; c < 16; c++) begin
          dout_rdy = rdy_pat[3 - (c % 4)];
          @(posedge clk);
          #1;
        end
        dout_rdy = 1'b1;
      end
    join

    // Requester 2 drops valid for 5 cycles after 3 beats.
    push_seq(2, 16'd4, 16'd6, 16'd1000);
    drive_req(2, 16'd4, 16'd6, 16'd1000, 3, 5);

    // Asynchronous reset in the middle of a requester 1 sequence.
    @(posedge clk);
    #1;
    req_cfg[1] = {16'd2, 16'd8, 16'd100};
    req_vld[1] = 1'b1;
    push_seq(1, 16'd2, 16'd8, 16'd100);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    exp_q.delete();
    req_vld[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the pointer is 0: all four valid -> 0,1,2,3, then 0 again.
    push_seq(0, 16'd1, 16'd2, 16'd500);
    push_seq(1, 16'd1, 16'd2, 16'd600);
    push_seq(2, 16'd1, 16'd2, 16'd700);
    push_seq(3, 16'd1, 16'd2, 16'd800);
    push_seq(0, 16'd9, 16'd2, 16'd900);
    gap_from_cyc = cyc;
    gap_en       = 1'b1;
    fork
      begin
        drive_req(0, 16'd1, 16'd2, 16'd500, 0, 0);
        drive_req(0, 16'd9, 16'd2, 16'd900, 0, 0);
      end
      drive_req(1, 16'd1, 16'd2, 16'd600, 0, 0);
      drive_req(2, 16'd1, 16'd2, 16'd700, 0, 0);
      drive_req(3, 16'd1, 16'd2, 16'd800, 0, 0);
    join
    gap_en = 1'b0;

    repeat (4) @(negedge clk);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_grant_id", 64'(grant_id), 64'd0);
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
